// File: rtl/vcfg_responder.sv
// vcfg_responder: responder for vector configuration ops (vsetvli/vsetivli/vsetvl).
// Decodes the request, computes the new vl/vtype against the global VLMAX and
// returns the new vl through an in-order response FIFO.
// Build option: VCFG_RESP_VILL_TRAP_EN -- when defined, an illegal vtype also
// raises resp_exception_o (result stays 0).
module vcfg_responder #(
    parameter int unsigned NrClusters = 4,
    parameter int unsigned VLEN       = 1024,
    parameter int unsigned ELEN       = 64,
    parameter int unsigned RespDepth  = 2,
    parameter int unsigned TransIdW   = 4,
    parameter int unsigned VlW        = $clog2(VLEN * NrClusters) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_insn_i,
    input  logic [63:0]         req_rs1_i,
    input  logic [63:0]         req_rs2_i,
    input  logic [TransIdW-1:0] req_trans_id_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [63:0]         resp_result_o,
    output logic                resp_exception_o,
    output logic [TransIdW-1:0] resp_trans_id_o,
    output logic [VlW-1:0]      vl_o,
    output logic [8:0]          vtype_o
);

    localparam int unsigned PtrW      = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW      = $clog2(RespDepth + 1);
    localparam int unsigned EntW      = 64 + 1 + TransIdW;
    localparam logic [2:0]  MaxSew    = 3'($clog2(ELEN / 8));
    localparam logic [VlW-1:0] VlMaxBase = VlW'((VLEN / 8) * NrClusters);
`ifdef VCFG_RESP_VILL_TRAP_EN
    localparam logic TrapIllegal = 1'b1;
`else
    localparam logic TrapIllegal = 1'b0;
`endif

    logic [VlW-1:0]      vl_q;
    logic [8:0]          vtype_q;
    logic [CntW-1:0]     count_q, count_d;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [EntW-1:0]     mem_q [RespDepth];

    logic                is_opcfg_s, is_vsetvli_s, is_vsetivli_s, is_vsetvl_s;
    logic [7:0]          raw_vtype_s;
    logic                raw_vill_s;
    logic [2:0]          vsew_s, vlmul_s;
    logic signed [4:0]   lmul_sum_s;
    logic                illegal_s;
    logic [VlW-1:0]      vlmax_sew_s, vlmax_s, uimm_s;
    logic [VlW-1:0]      next_vl_s;
    logic [8:0]          next_vtype_s;
    logic [63:0]         ent_result_s;
    logic                ent_exc_s;
    logic                push_s, pop_s;
    logic [EntW-1:0]     head_s;

    assign req_ready_o  = (count_q < CntW'(RespDepth));
    assign resp_valid_o = (count_q != {CntW{1'b0}});
    assign push_s       = req_valid_i && req_ready_o;
    assign pop_s        = resp_valid_o && resp_ready_i;
    assign head_s       = mem_q[rd_ptr_q];
    assign vl_o         = vl_q;
    assign vtype_o      = vtype_q;

    // Decode the request and derive the new vl/vtype plus the response entry.
    always_comb begin
        is_opcfg_s    = (req_insn_i[6:0] == 7'b1010111) && (req_insn_i[14:12] == 3'b111);
        is_vsetvli_s  = is_opcfg_s && !req_insn_i[31];
        is_vsetivli_s = is_opcfg_s && (req_insn_i[31:30] == 2'b11);
        is_vsetvl_s   = is_opcfg_s && (req_insn_i[31:25] == 7'b1000000);
        if (is_vsetvl_s) begin
            raw_vtype_s = req_rs2_i[7:0];
            raw_vill_s  = req_rs2_i[63];
        end else begin
            raw_vtype_s = req_insn_i[27:20];
            raw_vill_s  = 1'b0;
        end
        vsew_s      = raw_vtype_s[5:3];
        vlmul_s     = raw_vtype_s[2:0];
        // Fractional LMUL must still hold one element of the widest legal SEW.
        lmul_sum_s  = $signed({2'b00, MaxSew}) + $signed({{2{vlmul_s[2]}}, vlmul_s});
        illegal_s   = raw_vill_s || (vsew_s > MaxSew) || (vlmul_s == 3'b100) ||
                      (lmul_sum_s < $signed({2'b00, vsew_s}));
        vlmax_sew_s = VlMaxBase >> vsew_s;
        vlmax_s     = vlmul_s[2] ? (vlmax_sew_s >> (3'd0 - vlmul_s)) : (vlmax_sew_s << vlmul_s[1:0]);
        uimm_s      = VlW'(req_insn_i[19:15]);

        next_vl_s    = vl_q;
        next_vtype_s = vtype_q;
        ent_result_s = 64'd0;
        ent_exc_s    = 1'b1;
        if (!(is_vsetvli_s || is_vsetivli_s || is_vsetvl_s)) begin
            next_vl_s    = vl_q;
            next_vtype_s = vtype_q;
        end else if (illegal_s) begin
            next_vl_s    = {VlW{1'b0}};
            next_vtype_s = 9'h100;
            ent_exc_s    = TrapIllegal;
        end else begin
            next_vtype_s = {1'b0, raw_vtype_s};
            if (is_vsetivli_s) begin
                next_vl_s = (uimm_s > vlmax_s) ? vlmax_s : uimm_s;
            end else if ((req_insn_i[19:15] == 5'd0) && (req_insn_i[11:7] == 5'd0)) begin
                next_vl_s = vl_q;
            end else if (req_insn_i[19:15] == 5'd0) begin
                next_vl_s = vlmax_s;
            end else if (req_rs1_i > 64'(vlmax_s)) begin
                next_vl_s = vlmax_s;
            end else begin
                next_vl_s = req_rs1_i[VlW-1:0];
            end
            ent_result_s = 64'(next_vl_s);
            ent_exc_s    = 1'b0;
        end
    end

    // FIFO occupancy: push and pop together leave the count unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Architectural state and FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vl_q     <= {VlW{1'b0}};
            vtype_q  <= 9'h100;
            count_q  <= {CntW{1'b0}};
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
        end else begin
            count_q <= count_d;
            if (push_s) begin
                vl_q     <= next_vl_s;
                vtype_q  <= next_vtype_s;
                wr_ptr_q <= (wr_ptr_q == PtrW'(RespDepth - 1)) ? {PtrW{1'b0}} : wr_ptr_q + PtrW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(RespDepth - 1)) ? {PtrW{1'b0}} : rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Response storage, cleared on reset so no stale entry survives.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RespDepth); i++) begin
                mem_q[i] <= {EntW{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {ent_result_s, ent_exc_s, req_trans_id_i};
        end
    end

    // Present the FIFO head; drive zeros while nothing is pending.
    always_comb begin
        if (resp_valid_o) begin
            resp_result_o    = head_s[EntW-1 -: 64];
            resp_exception_o = head_s[TransIdW];
            resp_trans_id_o  = head_s[TransIdW-1:0];
        end else begin
            resp_result_o    = 64'd0;
            resp_exception_o = 1'b0;
            resp_trans_id_o  = {TransIdW{1'b0}};
        end
    end

endmodule

// File: tb/tb_vcfg_responder.sv
// Testbench for vcfg_responder: directed scenarios plus randomized traffic,
// checked against a behavioural model (vl rules computed from SEW/LMUL arithmetic,
// response FIFO kept as a queue).
module tb_vcfg_responder;

    localparam int NR    = 4;
    localparam int VLEN  = 1024;
    localparam int ELEN  = 64;
    localparam int DEPTH = 2;
    localparam int IDW   = 4;
    localparam int VLW   = 13;

    typedef struct packed {
        logic [63:0] res;
        logic        exc;
        logic [3:0]  id;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [31:0]     req_insn = 32'd0;
    logic [63:0]     req_rs1 = 64'd0;
    logic [63:0]     req_rs2 = 64'd0;
    logic [IDW-1:0]  req_id = 4'd0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [63:0]     resp_result;
    logic            resp_exc;
    logic [IDW-1:0]  resp_id;
    logic [VLW-1:0]  vl;
    logic [8:0]      vtype;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_vl;
    logic [8:0] m_vtype;
    ent_t mq[$];

    always #5 clk = ~clk;

    vcfg_responder #(
        .NrClusters(NR), .VLEN(VLEN), .ELEN(ELEN), .RespDepth(DEPTH), .TransIdW(IDW), .VlW(VLW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_insn_i(req_insn),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_trans_id_i(req_id),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_result_o(resp_result),
        .resp_exception_o(resp_exc), .resp_trans_id_o(resp_id),
        .vl_o(vl), .vtype_o(vtype)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_vsetvli(input logic [4:0] rd, input logic [4:0] rs1f, input logic [7:0] vt);
        return {1'b0, 3'b000, vt, rs1f, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] mk_vsetivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [7:0] vt);
        return {2'b11, 2'b00, vt, uimm, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] mk_vsetvl(input logic [4:0] rd, input logic [4:0] rs1f, input logic [4:0] rs2f);
        return {7'b1000000, rs2f, rs1f, 3'b111, rd, 7'b1010111};
    endfunction

    // Reference behaviour: updates the model vl/vtype and returns the response.
    task automatic model_exec(input logic [31:0] insn, input logic [63:0] rs1, input logic [63:0] rs2,
                              output logic [63:0] res, output logic exc);
        logic [7:0] vt;
        logic       vill;
        int         kind;
        int         sew_bits, code, vlmax;
        logic       legal;
        vt   = insn[27:20];
        vill = 1'b0;
        kind = 0;
        if (insn[6:0] == 7'b1010111 && insn[14:12] == 3'b111) begin
            if (!insn[31]) kind = 1;
            else if (insn[31:30] == 2'b11) kind = 2;
            else if (insn[31:25] == 7'b1000000) begin
                kind = 3;
                vt   = rs2[7:0];
                vill = rs2[63];
            end
        end
        res = 64'd0;
        exc = 1'b1;
        if (kind != 0) begin
            sew_bits = 8 << vt[5:3];
            code     = int'(vt[2:0]);
            legal    = !vill && (sew_bits <= ELEN) && (code != 4) &&
                       ((code < 4) || ((sew_bits << (8 - code)) <= ELEN));
            if (code < 4) vlmax = ((VLEN * NR) << code) / sew_bits;
            else          vlmax = (VLEN * NR) / (sew_bits << (8 - code));
            if (!legal) begin
                m_vl    = 0;
                m_vtype = 9'h100;
`ifdef VCFG_RESP_VILL_TRAP_EN
                exc = 1'b1;
`else
                exc = 1'b0;
`endif
            end else begin
                m_vtype = {1'b0, vt};
                if (kind == 2) m_vl = (int'(insn[19:15]) < vlmax) ? int'(insn[19:15]) : vlmax;
                else if (insn[19:15] == 5'd0 && insn[11:7] == 5'd0) m_vl = m_vl;
                else if (insn[19:15] == 5'd0) m_vl = vlmax;
                else if (rs1 > 64'(vlmax)) m_vl = vlmax;
                else m_vl = int'(rs1[31:0]);
                res = 64'(m_vl);
                exc = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, check outputs, advance the model.
    task automatic cycle(input logic v, input logic [31:0] insn, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [3:0] id, input logic rdy);
        ent_t e;
        logic acc;
        logic pop;
        req_valid  = v;
        req_insn   = insn;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_id     = id;
        resp_ready = rdy;
        #1;
        chk("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
        chk("resp_valid", 64'(resp_valid), 64'(mq.size() != 0));
        chk("vl", 64'(vl), 64'(m_vl));
        chk("vtype", 64'(vtype), 64'(m_vtype));
        if (mq.size() != 0) begin
            chk("resp_result", resp_result, mq[0].res);
            chk("resp_exc", 64'(resp_exc), 64'(mq[0].exc));
            chk("resp_id", 64'(resp_id), 64'(mq[0].id));
        end
        acc = v && (mq.size() < DEPTH);
        pop = (mq.size() != 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            model_exec(insn, rs1, rs2, e.res, e.exc);
            e.id = id;
            mq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        resp_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_vl = 0;
        m_vtype = 9'h100;
    endtask

    task automatic gen(output logic [31:0] insn, output logic [63:0] rs1, output logic [63:0] rs2);
        int kind;
        logic [7:0] vt;
        logic [4:0] rd, r1, r2;
        kind = $urandom_range(0, 9);
        vt   = 8'($urandom_range(0, 255));
        rd   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r1   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r2   = 5'($urandom_range(0, 31));
        rs1  = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 5000));
        rs2  = {($urandom_range(0, 7) == 0), 55'd0, vt};
        if (kind <= 3)      insn = mk_vsetvli(rd, r1, vt);
        else if (kind <= 5) insn = mk_vsetivli(rd, r1, vt);
        else if (kind <= 7) insn = mk_vsetvl(rd, r1, r2);
        else if (kind == 8) insn = {25'($urandom), 7'b0000111};
        else                insn = 32'($urandom);
    endtask

    initial begin
        logic [31:0] insn;
        logic [63:0] rs1, rs2;
        int sv_vl;
        logic [8:0] sv_vtype;
        m_vl = 0;
        m_vtype = 9'h100;
        @(negedge clk);
        do_reset();
        chk("t1_vl", 64'(vl), 64'd0);
        chk("t1_vtype", 64'(vtype), 64'h100);
        chk("t1_resp_valid", 64'(resp_valid), 64'd0);
        chk("t1_req_ready", 64'(req_ready), 64'd1);

        // vsetvli e32 m1 with AVL 200
        cycle(1'b1, mk_vsetvli(5'd1, 5'd2, 8'h10), 64'd200, 64'd0, 4'h3, 1'b1);
        chk("t2_vl", 64'(vl), 64'd128);
        chk("t2_result", resp_result, 64'd128);
        chk("t2_id", 64'(resp_id), 64'h3);
        // vsetvli e8 m8, rs1=x0 rd!=x0 then rs1=x0 rd=x0
        cycle(1'b1, mk_vsetvli(5'd1, 5'd0, 8'h03), 64'd0, 64'd0, 4'h4, 1'b1);
        chk("t3_vlmax", 64'(vl), 64'd4096);
        cycle(1'b1, mk_vsetvli(5'd0, 5'd0, 8'h03), 64'd0, 64'd0, 4'h5, 1'b1);
        chk("t3_keep", 64'(vl), 64'd4096);
        // vsetivli e16 mf2 uimm 7, then vsetvl e64 mf8 (illegal)
        cycle(1'b1, mk_vsetivli(5'd1, 5'd7, 8'h0F), 64'd0, 64'd0, 4'h6, 1'b1);
        chk("t4_vl", 64'(vl), 64'd7);
        chk("t4_vtype", 64'(vtype), 64'h00F);
        cycle(1'b1, mk_vsetvl(5'd1, 5'd2, 5'd3), 64'd50, 64'h1D, 4'h7, 1'b1);
        chk("t4_vill_vtype", 64'(vtype), 64'h100);
        chk("t4_vill_vl", 64'(vl), 64'd0);
        chk("t4_vill_result", resp_result, 64'd0);
`ifdef VCFG_RESP_VILL_TRAP_EN
        chk("t4_vill_exc", 64'(resp_exc), 64'd1);
`else
        chk("t4_vill_exc", 64'(resp_exc), 64'd0);
`endif
        cycle(1'b0, 32'd0, 64'd0, 64'd0, 4'h0, 1'b1);

        // back-pressure: three requests with resp_ready low
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, mk_vsetvli(5'd1, 5'd2, 8'h08), 64'(10 + i), 64'd0, 4'(8 + i), 1'b0);
        end
        chk("t5_full", 64'(req_ready), 64'd0);
        chk("t5_head_id", 64'(resp_id), 64'h8);
        cycle(1'b1, mk_vsetvli(5'd1, 5'd2, 8'h08), 64'd12, 64'd0, 4'hA, 1'b1);
        chk("t5_after_pop", 64'(req_ready), 64'd1);
        chk("t5_head2_id", 64'(resp_id), 64'h9);
        cycle(1'b1, mk_vsetvli(5'd1, 5'd2, 8'h08), 64'd12, 64'd0, 4'hA, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 64'd0, 64'd0, 4'h0, 1'b1);

        // non-OPCFG request leaves state alone
        sv_vl = m_vl;
        sv_vtype = m_vtype;
        cycle(1'b1, {25'h12345, 7'b0000111}, 64'd99, 64'd0, 4'hC, 1'b1);
        chk("t6_result", resp_result, 64'd0);
        chk("t6_exc", 64'(resp_exc), 64'd1);
        chk("t6_vl", 64'(vl), 64'(sv_vl));
        chk("t6_vtype", 64'(vtype), 64'(sv_vtype));
        // fill the FIFO and reset mid-transaction
        cycle(1'b1, mk_vsetvli(5'd1, 5'd2, 8'h10), 64'd5, 64'd0, 4'h1, 1'b0);
        cycle(1'b1, mk_vsetvli(5'd1, 5'd2, 8'h10), 64'd6, 64'd0, 4'h2, 1'b0);
        chk("t6_two_held", 64'(req_ready), 64'd0);
        do_reset();
        chk("t6_rst_vl", 64'(vl), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            gen(insn, rs1, rs2);
            cycle(($urandom_range(0, 9) < 7), insn, rs1, rs2, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 64'd0, 64'd0, 4'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
